pipeline_ks_subtractor_64: RTL and testbench



---
 rtl/pipeline_ks_subtractor_64.sv | 151 +++++++++++++++
 tb/tb_pipeline_ks_subtractor_64.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ks_subtractor_64.sv
// 4-stage pipelined Kogge-Stone subtractor: diff = a - b - bin.
// The subtraction is computed as a + ~b + ~bin, so the prefix network is that
// of an adder. A valid/ready handshake stalls the whole pipeline at once.
module pipeline_ks_subtractor_64 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LOG2W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // Stage 2 takes the first half of the prefix levels (rounded up), stage 3 the rest.
  localparam int unsigned LVL_S2 = (LOG2W + 1) / 2;

  // Runs Kogge-Stone prefix levels [lvl_lo, lvl_hi) over (G, P); returns {G, P}.
  function automatic logic [2*WIDTH-1:0] ks_levels(
    input logic [WIDTH-1:0] g_in,
    input logic [WIDTH-1:0] p_in,
    input int unsigned      lvl_lo,
    input int unsigned      lvl_hi
  );
    logic [WIDTH-1:0] g, p, g_n, p_n;
    int unsigned      span;
    g = g_in;
    p = p_in;
    for (int unsigned l = lvl_lo; l < lvl_hi; l++) begin
      span = 32'd1 << l;
      g_n  = g;
      p_n  = p;
      for (int unsigned i = span; i < WIDTH; i++) begin
        g_n[i] = g[i] | (p[i] & g[i - span]);
        p_n[i] = p[i] & p[i - span];
      end
      g = g_n;
      p = p_n;
    end
    return {g, p};
  endfunction

  // Pipeline state
  logic             v1, v2, v3, v4;
  logic [WIDTH-1:0] s1_g, s1_p;
  logic             s1_c0, s1_sa, s1_sb;
  logic [WIDTH-1:0] s2_gg, s2_gp, s2_p;
  logic             s2_c0, s2_sa, s2_sb;
  logic [WIDTH-1:0] s3_gg, s3_gp, s3_p;
  logic             s3_c0, s3_sa, s3_sb;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r, ovf_r;

  // Combinational next-stage values
  logic             advance;
  logic [WIDTH-1:0] s2_gg_nxt, s2_gp_nxt;
  logic [WIDTH-1:0] s3_gg_nxt, s3_gp_nxt;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] diff_nxt;
  logic             bout_nxt, ovf_nxt;

  // Global stall: everything moves only when the output slot is free or draining.
  always_comb begin
    advance  = ~v4 | out_ready;
    in_ready = advance;
  end

  // Prefix levels for stages 2 and 3, then final carries and result for stage 4.
  always_comb begin
    {s2_gg_nxt, s2_gp_nxt} = ks_levels(s1_g, s1_p, 0, LVL_S2);
    {s3_gg_nxt, s3_gp_nxt} = ks_levels(s2_gg, s2_gp, LVL_S2, LOG2W);
    carry    = {s3_gg | (s3_gp & {WIDTH{s3_c0}}), s3_c0};
    diff_nxt = s3_p ^ carry[WIDTH-1:0];
    bout_nxt = ~carry[WIDTH];
    ovf_nxt  = (s3_sa != s3_sb) && (diff_nxt[WIDTH-1] != s3_sa);
  end

  // Pipeline registers: all stages shift together on advance, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      v4     <= 1'b0;
      s1_g   <= '0;
      s1_p   <= '0;
      s1_c0  <= 1'b0;
      s1_sa  <= 1'b0;
      s1_sb  <= 1'b0;
      s2_gg  <= '0;
      s2_gp  <= '0;
      s2_p   <= '0;
      s2_c0  <= 1'b0;
      s2_sa  <= 1'b0;
      s2_sb  <= 1'b0;
      s3_gg  <= '0;
      s3_gp  <= '0;
      s3_p   <= '0;
      s3_c0  <= 1'b0;
      s3_sa  <= 1'b0;
      s3_sb  <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (advance) begin
      v1     <= in_valid;
      s1_g   <= a & ~b;
      s1_p   <= a ^ ~b;
      s1_c0  <= ~bin;
      s1_sa  <= a[WIDTH-1];
      s1_sb  <= b[WIDTH-1];

      v2     <= v1;
      s2_gg  <= s2_gg_nxt;
      s2_gp  <= s2_gp_nxt;
      s2_p   <= s1_p;
      s2_c0  <= s1_c0;
      s2_sa  <= s1_sa;
      s2_sb  <= s1_sb;

      v3     <= v2;
      s3_gg  <= s3_gg_nxt;
      s3_gp  <= s3_gp_nxt;
      s3_p   <= s2_p;
      s3_c0  <= s2_c0;
      s3_sa  <= s2_sa;
      s3_sb  <= s2_sb;

      v4     <= v3;
      diff_r <= diff_nxt;
      bout_r <= bout_nxt;
      ovf_r  <= ovf_nxt;
    end
  end

  // Registered outputs
  always_comb begin
    out_valid = v4;
    diff      = diff_r;
    bout      = bout_r;
    ovf       = ovf_r;
  end

endmodule

// File: tb/tb_pipeline_ks_subtractor_64.sv
// Directed testbench for pipeline_ks_subtractor_64.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_pipeline_ks_subtractor_64;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W+1:0] rx_q[$];
  int           rx_cyc[$];

  pipeline_ks_subtractor_64 #(.WIDTH(64), .LOG2W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer (valid && ready seen just before the edge).
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      rx_q.push_back({diff, bout, ovf});
      rx_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input string name);
    int budget = 60;
    while (rx_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d results, expected %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    #3;
    checks++;
    if ({out_valid, diff, bout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h bo=%b ov=%b, expected all 0", out_valid, diff, bout, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    step();
    rx_q.delete(); rx_cyc.delete();
    a = 64'd300; b = 64'd200; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (c == 4)) begin
        errors++;
        $display("FAIL basic_latency c%0d: got out_valid=%b expected %b", c, out_valid, (c == 4));
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_in_ready c%0d: got %b expected 1", c, in_ready);
      end
      if (c == 4) begin
        checks++;
        if ({diff, bout, ovf} !== {64'd100, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL basic_value: got d=%h bo=%b ov=%b expected d=%h bo=0 ov=0", diff, bout, ovf, 64'd100);
        end
      end
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] va[5], vb[5], ed[5];
    logic         vbin[5], eb[5], eo[5];
    va[0] = '0;                    vb[0] = '0;                    vbin[0] = 1'b1;
    ed[0] = '1;                    eb[0] = 1'b1; eo[0] = 1'b0;
    va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'd1;               vbin[1] = 1'b0;
    ed[1] = 64'h7FFF_FFFF_FFFF_FFFF; eb[1] = 1'b0; eo[1] = 1'b1;
    va[2] = 64'h1234_5678_9ABC_DEF0; vb[2] = 64'h1234_5678_9ABC_DEF0; vbin[2] = 1'b0;
    ed[2] = '0;                    eb[2] = 1'b0; eo[2] = 1'b0;
    va[3] = '1;                    vb[3] = '1;                    vbin[3] = 1'b1;
    ed[3] = '1;                    eb[3] = 1'b1; eo[3] = 1'b0;
    va[4] = 64'h7FFF_FFFF_FFFF_FFFF; vb[4] = '1;                  vbin[4] = 1'b0;
    ed[4] = 64'h8000_0000_0000_0000; eb[4] = 1'b1; eo[4] = 1'b1;
    step();
    rx_q.delete(); rx_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = va[i]; b = vb[i]; bin = vbin[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_rx(5, "boundary");
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== {ed[i], eb[i], eo[i]}) begin
        errors++;
        $display("FAIL boundary_%0d: got d=%h bo=%b ov=%b expected d=%h bo=%b ov=%b",
                 i, rx_q[i][W+1:2], rx_q[i][1], rx_q[i][0], ed[i], eb[i], eo[i]);
      end
    end
  endtask

  task automatic test_streaming();
    step();
    rx_q.delete(); rx_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 64'(i); b = 64'(200 + i); bin = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_rx(10, "stream");
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== {64'hFFFF_FFFF_FFFF_FF38, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stream_%0d: got d=%h bo=%b ov=%b expected d=ffffffffffffff38 bo=1 ov=0",
                 i, rx_q[i][W+1:2], rx_q[i][1], rx_q[i][0]);
      end
      if (i > 0) begin
        checks++;
        if (rx_cyc[i] != rx_cyc[i-1] + 1) begin
          errors++;
          $display("FAIL stream_rate_%0d: got gap %0d expected 1", i, rx_cyc[i] - rx_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ed[8];
    logic [W+1:0] held;
    logic         have_held, acc;
    int k, t, stall_cnt;
    ed[0] = 64'd1000; ed[1] = 64'd1008; ed[2] = 64'd1018; ed[3] = 64'd1026;
    ed[4] = 64'd1036; ed[5] = 64'd1044; ed[6] = 64'd1054; ed[7] = 64'd1062;
    step();
    rx_q.delete(); rx_cyc.delete();
    k = 0; t = 0; stall_cnt = 0; have_held = 1'b0; held = '0;
    while (k < 8 && t < 60) begin
      a = 64'(1000 + 10 * k); b = 64'(k); bin = k[0]; in_valid = 1'b1;
      out_ready = !(t >= 5 && t < 10);
      @(negedge clk);
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL bp_in_ready t%0d: got %b expected %b", t, in_ready, (!out_valid || out_ready));
      end
      if (!in_ready) stall_cnt++;
      if (out_valid && !out_ready) begin
        if (have_held) begin
          checks++;
          if ({diff, bout, ovf} !== held) begin
            errors++;
            $display("FAIL bp_hold t%0d: got %h expected %h", t, {diff, bout, ovf}, held);
          end
        end
        held = {diff, bout, ovf};
        have_held = 1'b1;
      end else begin
        have_held = 1'b0;
      end
      acc = in_ready;
      step();
      if (acc) k++;
      t++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (stall_cnt != 5) begin
      errors++;
      $display("FAIL bp_stall_cycles: got %0d expected 5", stall_cnt);
    end
    wait_rx(8, "bp");
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== {ed[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_order_%0d: got d=%0d bo=%b ov=%b expected d=%0d bo=0 ov=0",
                 i, rx_q[i][W+1:2], rx_q[i][1], rx_q[i][0], ed[i]);
      end
    end
  endtask

  task automatic test_bubbles();
    logic pat[6];
    logic exp_v;
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 1;
    step();
    out_ready = 1'b1;
    for (int s = 0; s < 12; s++) begin
      if (s < 6) begin
        a = 64'(50 + s); b = 64'd7; bin = 1'b0; in_valid = pat[s];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      exp_v = (s >= 4 && s < 10) ? pat[s-4] : 1'b0;
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL bubble_valid s%0d: got %b expected %b", s, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if ({diff, bout, ovf} !== {64'(43 + s - 4), 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL bubble_value s%0d: got d=%0d expected %0d", s, diff, 43 + s - 4);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 64'(9 + i); b = 64'd4; bin = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b1 || diff !== 64'd5) begin
      errors++;
      $display("FAIL rmid_before: got v=%b d=%0d expected v=1 d=5", out_valid, diff);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, diff, bout, ovf} !== '0) begin
      errors++;
      $display("FAIL rmid_clear: got v=%b d=%h bo=%b ov=%b expected all 0", out_valid, diff, bout, ovf);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    rx_q.delete(); rx_cyc.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_stale c%0d: got out_valid=%b expected 0", c, out_valid);
      end
    end
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("FAIL rmid_results: got %0d expected 0", rx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_streaming();
    test_back_to_back();
    test_bubbles();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
